// File: rtl/oc8051_fetch_pkg.sv
// Shared constants and types for the oc8051 instruction prefetch stage.
package oc8051_fetch_pkg;

    localparam int FETCH_BYTES = 4;
    localparam int OP_BYTES    = 3;

    typedef enum logic [1:0] {
        CONSUME_NONE  = 2'd0,
        CONSUME_ONE   = 2'd1,
        CONSUME_TWO   = 2'd2,
        CONSUME_THREE = 2'd3
    } consume_e;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/oc8051_fetch_queue.sv
// Circular byte queue: 4-byte write port, 3-byte read window at head,
// variable pop of 0-3 bytes and a flush that empties it.
module oc8051_fetch_queue
    import oc8051_fetch_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int PW    = ptr_width(DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          wr_en_i,
    input  logic [31:0]   wr_data_i,
    input  logic [1:0]    pop_i,
    output logic [23:0]   rd_data_o,
    output logic [PW:0]   count_o
);

    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;

    // Pointer and occupancy next-state; the caller guarantees pops never exceed count.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d = head_q + PW'(pop_i);
            if (wr_en_i) begin
                tail_d  = tail_q + PW'(FETCH_BYTES);
                count_d = count_q + (PW+1)'(FETCH_BYTES) - (PW+1)'(pop_i);
            end else begin
                count_d = count_q - (PW+1)'(pop_i);
            end
        end
    end

    // Storage is cleared on reset so the read window shows zeros afterwards.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            if (wr_en_i && !flush_i) begin
                for (int k = 0; k < FETCH_BYTES; k++) begin
                    mem_q[tail_q + PW'(k)] <= wr_data_i[8*k +: 8];
                end
            end
        end
    end

    // Read window of the next instruction bytes starting at head.
    always_comb begin
        rd_data_o = 24'h000000;
        for (int k = 0; k < OP_BYTES; k++) begin
            rd_data_o[8*k +: 8] = mem_q[head_q + PW'(k)];
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/oc8051_cxrom_fetch.sv
// oc8051 instruction prefetch: drives the code ROM address, buffers ROM words
// and presents the next three opcode bytes with their PC to decode.
module oc8051_cxrom_fetch
    import oc8051_fetch_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    output logic [AW-1:0] cxrom_addr,
    input  logic [31:0]   cxrom_data_in,
    input  logic          pc_load,
    input  logic [AW-1:0] pc_new,
    input  logic [1:0]    consume,
    output logic          op_valid,
    output logic [23:0]   op_data,
    output logic [AW-1:0] op_pc
);

    localparam int           PW          = ptr_width(DEPTH);
    localparam logic [PW:0]  FETCH_LIMIT = (PW+1)'(DEPTH - FETCH_BYTES);

    logic [AW-1:0] fetch_pc_q, fetch_pc_d;
    logic [AW-1:0] op_pc_q, op_pc_d;
    logic [PW:0]   count_s;
    logic          fetch_s;
    logic [1:0]    pop_s;

    // Fetch uses the pre-consume count; consume is honoured only with a full window.
    always_comb begin
        fetch_s  = 1'b0;
        pop_s    = 2'd0;
        op_valid = (count_s >= (PW+1)'(OP_BYTES));
        if (!pc_load && (count_s <= FETCH_LIMIT)) begin
            fetch_s = 1'b1;
        end else begin
            fetch_s = 1'b0;
        end
        if (op_valid && (consume_e'(consume) != CONSUME_NONE)) begin
            pop_s = consume;
        end else begin
            pop_s = 2'd0;
        end
    end

    // A jump overrides both fetch and consume in its cycle.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        op_pc_d    = op_pc_q;
        if (pc_load) begin
            fetch_pc_d = pc_new;
            op_pc_d    = pc_new;
        end else begin
            op_pc_d = op_pc_q + AW'(pop_s);
            if (fetch_s) begin
                fetch_pc_d = fetch_pc_q + AW'(FETCH_BYTES);
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
        end
    end

    // Program counters; reset wins over a simultaneous jump.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= '0;
            op_pc_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            op_pc_q    <= op_pc_d;
        end
    end

    oc8051_fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk_i     (clk),
        .rst_i     (rst),
        .flush_i   (pc_load),
        .wr_en_i   (fetch_s),
        .wr_data_i (cxrom_data_in),
        .pop_i     (pop_s),
        .rd_data_o (op_data),
        .count_o   (count_s)
    );

    assign cxrom_addr = fetch_pc_q;
    assign op_pc      = op_pc_q;

endmodule

// File: tb/tb_oc8051_cxrom_fetch.sv
// Self-checking bench for oc8051_cxrom_fetch: byte-queue reference model plus
// directed scenarios with hand-computed expectations.
module tb_oc8051_cxrom_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cxrom_addr;
    logic [31:0] cxrom_data_in;
    logic        pc_load;
    logic [15:0] pc_new;
    logic [1:0]  consume;
    logic        op_valid;
    logic [23:0] op_data;
    logic [15:0] op_pc;

    int pass_cnt  = 0;
    int total_cnt = 0;
    bit chk_en    = 1'b0;

    // Reference model state
    logic [7:0]  mq[$];
    logic [15:0] m_fpc;
    logic [15:0] m_opc;

    always #5 clk = ~clk;

    oc8051_cxrom_fetch #(.DEPTH(8), .AW(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .cxrom_addr    (cxrom_addr),
        .cxrom_data_in (cxrom_data_in),
        .pc_load       (pc_load),
        .pc_new        (pc_new),
        .consume       (consume),
        .op_valid      (op_valid),
        .op_data       (op_data),
        .op_pc         (op_pc)
    );

    function automatic logic [7:0] rb(input logic [15:0] a);
        return a[7:0];
    endfunction

    // Combinational ROM: byte(a) = low byte of a
    assign cxrom_data_in = {rb(cxrom_addr + 16'd3), rb(cxrom_addr + 16'd2),
                            rb(cxrom_addr + 16'd1), rb(cxrom_addr)};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: queue of byte values in address order
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_fpc = 16'h0000;
            m_opc = 16'h0000;
        end else if (pc_load) begin
            mq.delete();
            m_fpc = pc_new;
            m_opc = pc_new;
        end else begin
            int  n;
            bit  do_fetch;
            n = mq.size();
            do_fetch = ((8 - n) >= 4);
            if (n >= 3 && consume != 2'd0) begin
                for (int i = 0; i < int'(consume); i++) void'(mq.pop_front());
                m_opc = m_opc + 16'(consume);
            end
            if (do_fetch) begin
                for (int k = 0; k < 4; k++) mq.push_back(rb(m_fpc + 16'(k)));
                m_fpc = m_fpc + 16'd4;
            end
        end
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (chk_en) begin
            check("cxrom_addr", {16'h0, cxrom_addr}, {16'h0, m_fpc});
            check("op_pc", {16'h0, op_pc}, {16'h0, m_opc});
            check("op_valid", {31'h0, op_valid}, {31'h0, (mq.size() >= 3)});
            check("count_le_depth", {31'h0, (dut.count_s <= 4'd8)}, 32'd1);
            if (mq.size() >= 3) begin
                check("op_data", {8'h0, op_data}, {8'h0, mq[2], mq[1], mq[0]});
                check("op_data_rom", {8'h0, op_data},
                      {8'h0, rb(op_pc + 16'd2), rb(op_pc + 16'd1), rb(op_pc)});
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        check(name, act, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; pc_load = 1'b0; pc_new = 16'h0000; consume = 2'd0;
        cyc();
        chk_en = 1'b1;
        cyc();
        rst = 1'b0;
        // Startup
        @(negedge clk);
        lit("rst_addr",  {16'h0, cxrom_addr}, 32'h0000_0000);
        lit("rst_valid", {31'h0, op_valid},   32'd0);
        lit("rst_data",  {8'h0, op_data},     32'h0000_0000);
        lit("rst_pc",    {16'h0, op_pc},      32'h0000_0000);
        cyc(); @(negedge clk);
        lit("start_valid", {31'h0, op_valid}, 32'd1);
        lit("start_data",  {8'h0, op_data},   32'h0002_0100);
        lit("start_pc",    {16'h0, op_pc},    32'h0000_0000);
        lit("start_addr1", {16'h0, cxrom_addr}, 32'h0000_0004);
        // Back-pressure
        cyc(); @(negedge clk);
        lit("bp_addr2", {16'h0, cxrom_addr}, 32'h0000_0008);
        cyc(); cyc(); @(negedge clk);
        lit("bp_hold_addr", {16'h0, cxrom_addr}, 32'h0000_0008);
        lit("bp_hold_data", {8'h0, op_data},     32'h0002_0100);
        // Streaming (model tracks the exact sequence)
        consume = 2'd3;
        cyc(); @(negedge clk);
        lit("stream_pc1", {16'h0, op_pc}, 32'h0000_0003);
        lit("stream_d1",  {8'h0, op_data}, 32'h0005_0403);
        for (int i = 0; i < 12; i++) cyc();
        consume = 2'd1;
        for (int i = 0; i < 5; i++) cyc();
        consume = 2'd0;
        cyc();
        // Jump priority over consume
        pc_load = 1'b1; pc_new = 16'h1234; consume = 2'd2;
        cyc();
        pc_load = 1'b0; consume = 2'd0;
        @(negedge clk);
        lit("jmp_valid", {31'h0, op_valid},   32'd0);
        lit("jmp_addr",  {16'h0, cxrom_addr}, 32'h0000_1234);
        cyc(); @(negedge clk);
        lit("jmp_pc",   {16'h0, op_pc},   32'h0000_1234);
        lit("jmp_data", {8'h0, op_data},  32'h0036_3534);
        // Address wrap
        pc_load = 1'b1; pc_new = 16'hFFFE;
        cyc();
        pc_load = 1'b0;
        cyc(); @(negedge clk);
        lit("wrap_data", {8'h0, op_data},     32'h0000_FFFE);
        lit("wrap_pc",   {16'h0, op_pc},      32'h0000_FFFE);
        lit("wrap_addr", {16'h0, cxrom_addr}, 32'h0000_0002);
        consume = 2'd3;
        cyc();
        consume = 2'd0;
        @(negedge clk);
        lit("wrap_pc2",   {16'h0, op_pc},  32'h0000_0001);
        lit("wrap_data2", {8'h0, op_data}, 32'h0003_0201);
        // Consume while invalid is ignored
        pc_load = 1'b1; pc_new = 16'h0100;
        cyc();
        pc_load = 1'b0; consume = 2'd3;
        cyc();
        consume = 2'd0;
        @(negedge clk);
        lit("inv_pc",    {16'h0, op_pc},   32'h0000_0100);
        lit("inv_valid", {31'h0, op_valid}, 32'd1);
        lit("inv_data",  {8'h0, op_data},  32'h0002_0100);
        // Mid-run reset with a half-full queue
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        @(negedge clk);
        lit("mrst_addr",  {16'h0, cxrom_addr}, 32'h0000_0000);
        lit("mrst_valid", {31'h0, op_valid},   32'd0);
        lit("mrst_data",  {8'h0, op_data},     32'h0000_0000);
        lit("mrst_pc",    {16'h0, op_pc},      32'h0000_0000);
        cyc(); @(negedge clk);
        lit("mrst_valid2", {31'h0, op_valid},   32'd1);
        lit("mrst_data2",  {8'h0, op_data},     32'h0002_0100);
        lit("mrst_addr2",  {16'h0, cxrom_addr}, 32'h0000_0004);
        cyc(); cyc();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
